// File: rtl/dshot_rx.sv
// DShot single-wire frame receiver: measures bit high times, assembles 16-bit frames,
// checks the 4-bit CRC and presents throttle/telemetry with one-cycle result strobes.
module dshot_rx #(
    parameter int BASE_FREQ  = 100_000_000,
    parameter int DSHOT_RATE = 600
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DSHOT_IN,
    output logic [10:0] THROTTLE,
    output logic        TELEM,
    output logic        FRAME_VALID,
    output logic        CRC_ERR,
    output logic        FRAME_ERR,
    output logic        BUSY
);

    localparam int PERIOD = BASE_FREQ / (DSHOT_RATE * 1000);
    localparam logic [15:0] THRESH    = 16'(PERIOD / 2);
    localparam logic [15:0] MIN_HIGH  = 16'(PERIOD / 8);
    localparam logic [15:0] MAX_HIGH  = 16'(PERIOD - PERIOD / 8);
    localparam logic [15:0] TIMEOUT_M1 = 16'(2 * PERIOD - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HIGH     = 3'd1;
    localparam logic [2:0] ST_LOW      = 3'd2;
    localparam logic [2:0] ST_WAIT_LOW = 3'd3;
    localparam logic [2:0] ST_CHECK    = 3'd4;

    logic        sync1_q, sync2_q, prev_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] shift_q, shift_d;
    logic [10:0] throttle_q, throttle_d;
    logic        telem_q, telem_d;
    logic        valid_q, valid_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  settle_q, settle_d;
    logic        armed_q, armed_d;

    logic        rise, fall;
    logic [11:0] payload;
    logic [3:0]  crc;

    assign rise    = sync2_q & ~prev_q;
    assign fall    = ~sync2_q & prev_q;
    assign payload = shift_q[15:4];
    assign crc     = payload[3:0] ^ payload[7:4] ^ payload[11:8];

    // A line already high when reset is released must fall before a frame may start:
    // arm only once the synchronizer has settled and shows low, or on a falling edge.
    always_comb begin
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | fall | ((settle_q == 2'd3) & ~sync2_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        throttle_d  = throttle_q;
        telem_d     = telem_q;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;

        if (rise || fall) begin
            cnt_d = 16'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise && armed_q) begin
                    state_d = ST_HIGH;
                    idx_d   = 4'd0;
                end
            end
            ST_HIGH: begin
                // The falling edge wins over overflow so WAIT_LOW never misses its edge.
                if (fall) begin
                    if (cnt_q < MIN_HIGH) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        shift_d = {shift_q[14:0], (cnt_q >= THRESH)};
                        if (idx_q == 4'd15) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = ST_LOW;
                        end
                    end
                end else if (cnt_q > MAX_HIGH) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (cnt_q >= TIMEOUT_M1) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (crc == shift_q[3:0]) begin
                    throttle_d = shift_q[15:5];
                    telem_d    = shift_q[4];
                    valid_d    = 1'b1;
                end else begin
                    crc_err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 4'd0;
            shift_q     <= 16'd0;
            throttle_q  <= 11'd0;
            telem_q     <= 1'b0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            sync1_q     <= DSHOT_IN;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            throttle_q  <= throttle_d;
            telem_q     <= telem_d;
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign THROTTLE    = throttle_q;
    assign TELEM       = telem_q;
    assign FRAME_VALID = valid_q;
    assign CRC_ERR     = crc_err_q;
    assign FRAME_ERR   = frame_err_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dshot_rx.sv
// Bench for dshot_rx: directed DShot frames with a scoreboard of expected result pulses.
module tb_dshot_rx;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        DSHOT_IN;
    logic [10:0] THROTTLE;
    logic        TELEM;
    logic        FRAME_VALID;
    logic        CRC_ERR;
    logic        FRAME_ERR;
    logic        BUSY;

    dshot_rx #(
        .BASE_FREQ  (100_000_000),
        .DSHOT_RATE (600)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DSHOT_IN    (DSHOT_IN),
        .THROTTLE    (THROTTLE),
        .TELEM       (TELEM),
        .FRAME_VALID (FRAME_VALID),
        .CRC_ERR     (CRC_ERR),
        .FRAME_ERR   (FRAME_ERR),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    localparam int H1 = 125;
    localparam int L1 = 41;
    localparam int H0 = 62;
    localparam int L0 = 104;
    localparam int K_VALID = 0;
    localparam int K_CRC   = 1;
    localparam int K_FERR  = 2;
    localparam int K_NONE  = -1;

    typedef struct {
        int          kind;
        int          thr;
        int          tel;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop one expectation per result pulse and compare kind, timing and fields.
    always @(negedge CLK) begin
        int   n;
        int   kind;
        exp_t e;
        n = int'(FRAME_VALID) + int'(CRC_ERR) + int'(FRAME_ERR);
        if (n > 1) check("pulse_onehot", n, 1);
        if (n == 1) begin
            kind = FRAME_VALID ? K_VALID : (CRC_ERR ? K_CRC : K_FERR);
            if (sb.size() == 0) begin
                check("unexpected_pulse_kind", kind, K_NONE);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_cycle", int'(cyc), int'(e.at));
                check("throttle", int'(THROTTLE), e.thr);
                check("telem", int'(TELEM), e.tel);
            end
        end
    end

    task automatic hold(input logic v, input int n);
        DSHOT_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input int kind, input int thr, input int tel, input int unsigned at);
        exp_t e;
        e.kind = kind;
        e.thr  = thr;
        e.tel  = tel;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Send the top nbits of f MSB first; the expectation is queued at the last falling edge.
    task automatic send_bits(input logic [15:0] f, input int nbits, input int kind,
                             input int thr, input int tel, input int delay, input int last_low);
        int unsigned fall_cyc;
        for (int i = 15; i > 15 - nbits; i--) begin
            hold(1'b1, f[i] ? H1 : H0);
            if (i == 15) check("busy_in_frame", int'(BUSY), 1);
            if (i == 16 - nbits) begin
                fall_cyc = cyc;
                if (kind != K_NONE) push(kind, thr, tel, fall_cyc + delay);
                hold(1'b0, (last_low > 0) ? last_low : (f[i] ? L1 : L0));
            end else begin
                hold(1'b0, f[i] ? L1 : L0);
            end
        end
    endtask

    initial begin
        int unsigned t;
        DSHOT_IN = 1'b0;
        RESET    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_throttle", int'(THROTTLE), 0);
        check("reset_telem", int'(TELEM), 0);
        check("reset_valid", int'(FRAME_VALID), 0);
        check("reset_crc_err", int'(CRC_ERR), 0);
        check("reset_frame_err", int'(FRAME_ERR), 0);
        check("reset_busy", int'(BUSY), 0);
        RESET = 1'b0;
        hold(1'b0, 10);

        // Valid frame 0x82C6: throttle 1046, telem 0, 4 cycles after final raw fall.
        send_bits(16'h82C6, 16, K_VALID, 1046, 0, 4, 0);
        hold(1'b0, 5);
        check("idle_busy", int'(BUSY), 0);

        // Bad CRC: throttle holds.
        send_bits(16'h82C7, 16, K_CRC, 1046, 0, 4, 0);
        hold(1'b0, 5);
        check("throttle_hold_after_crc", int'(THROTTLE), 1046);

        // Back-to-back with no extra gap.
        send_bits(16'h0011, 16, K_VALID, 0, 1, 4, 0);
        send_bits(16'hFFFF, 16, K_VALID, 2047, 1, 4, 0);
        hold(1'b0, 5);

        // Eight bits then low: timeout 335 cycles after the last raw fall.
        send_bits(16'h82C6, 8, K_FERR, 2047, 1, 335, 400);
        check("idle_after_timeout", int'(BUSY), 0);
        send_bits(16'h82C6, 16, K_VALID, 1046, 0, 4, 0);
        hold(1'b0, 5);

        // Short glitch from idle: error 3 cycles after its raw fall.
        hold(1'b1, 10);
        push(K_FERR, 1046, 0, cyc + 3);
        hold(1'b0, 20);
        check("idle_after_glitch", int'(BUSY), 0);

        // Stuck high: one error when the counter passes MAX_HIGH, silence until it falls.
        t = cyc;
        push(K_FERR, 1046, 0, t + 151);
        hold(1'b1, 300);
        check("busy_while_stuck", int'(BUSY), 1);
        hold(1'b0, 20);
        check("idle_after_stuck", int'(BUSY), 0);

        // Reset after ten bits: partial frame discarded, no pulse.
        send_bits(16'h82C6, 10, K_NONE, 0, 0, 0, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("midreset_throttle", int'(THROTTLE), 0);
        check("midreset_telem", int'(TELEM), 0);
        check("midreset_busy", int'(BUSY), 0);
        hold(1'b0, 10);
        send_bits(16'h82C6, 16, K_VALID, 1046, 0, 4, 0);
        hold(1'b0, 20);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
